spi_slave_top: RTL and testbench

SPI_SLAVE_TOP -- requirements
Module: spi_slave_top

---
 rtl/spi_slave_top.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_top.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_top.sv
// SPI slave with a four-register CPU interface (control, status, TX, RX).
// All SPI pins are resynchronised to clk; single-byte TX/RX buffers with under/overrun flags.
module spi_slave_top #(
    parameter int ADDR_LSB          = 0,
    parameter int OPT_MEM_ADDR_BITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic       miso_oe,
    output logic       irq
);
    localparam int SELW = OPT_MEM_ADDR_BITS + 1;
    localparam logic [SELW-1:0] SEL_CON  = SELW'(0);
    localparam logic [SELW-1:0] SEL_STAT = SELW'(1);
    localparam logic [SELW-1:0] SEL_TX   = SELW'(2);
    localparam logic [SELW-1:0] SEL_RX   = SELW'(3);

    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_mosi_meta, r_mosi_sync;
    logic r_ss_meta, r_ss_sync, r_ss_prev;

    logic       r_en, r_cpol, r_cpha, r_irq_en;
    logic       r_rx_full, r_tx_full, r_overrun, r_underrun;
    logic [7:0] r_txbuf, r_rxdata, r_tx_sh, r_dout;
    logic [6:0] r_rx_sh;
    logic [2:0] r_cnt;
    logic       r_irq;

    logic [SELW-1:0] w_sel;
    logic w_rd, w_wr, w_rd_rx, w_active, w_lead, w_trail;
    logic w_sample, w_shift, w_start, w_load, w_done;
    logic [7:0] w_rx_byte;
    logic w_unused;

    assign w_sel    = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
    assign w_unused = &{1'b0, addr};
    assign w_wr     = wr_en;
    assign w_rd     = rd_en & ~wr_en;
    assign w_rd_rx  = w_rd && (w_sel == SEL_RX);

    assign w_active  = r_en & ~r_ss_sync;
    assign w_lead    = w_active & (r_sclk_prev == r_cpol) & (r_sclk_sync != r_cpol);
    assign w_trail   = w_active & (r_sclk_prev != r_cpol) & (r_sclk_sync == r_cpol);
    assign w_sample  = r_cpha ? w_trail : w_lead;
    assign w_shift   = r_cpha ? w_lead : w_trail;
    assign w_start   = r_en & r_ss_prev & ~r_ss_sync;
    // CPHA=0 needs the first bit on the pin before the first edge, hence the load at frame start.
    assign w_load    = (w_start & ~r_cpha) | (w_shift & (r_cnt == 3'd0));
    assign w_done    = w_sample & (r_cnt == 3'd7);
    assign w_rx_byte = {r_rx_sh, r_mosi_sync};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_ss_meta   <= 1'b1;
            r_ss_sync   <= 1'b1;
            r_ss_prev   <= 1'b1;
            r_en        <= 1'b0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_irq_en    <= 1'b0;
            r_rx_full   <= 1'b0;
            r_tx_full   <= 1'b0;
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
            r_txbuf     <= 8'h00;
            r_rxdata    <= 8'h00;
            r_tx_sh     <= 8'hFF;
            r_rx_sh     <= 7'h00;
            r_cnt       <= 3'd0;
            r_dout      <= 8'h00;
            r_irq       <= 1'b0;
        end else begin
            r_sclk_meta <= sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
            r_ss_meta   <= ss_n;
            r_ss_sync   <= r_ss_meta;
            r_ss_prev   <= r_ss_sync;

            if (w_rd) begin
                if (w_sel == SEL_CON)
                    r_dout <= {4'h0, r_irq_en, r_cpha, r_cpol, r_en};
                else if (w_sel == SEL_STAT)
                    r_dout <= {3'b000, w_active, r_underrun, r_overrun, r_tx_full, r_rx_full};
                else if (w_sel == SEL_TX)
                    r_dout <= r_txbuf;
                else if (w_sel == SEL_RX)
                    r_dout <= r_rxdata;
                else
                    r_dout <= 8'h00;
            end

            if (w_wr && (w_sel == SEL_CON))
                {r_irq_en, r_cpha, r_cpol, r_en} <= din[3:0];
            // Status clears are placed first so a flag raised in the same clk is not lost.
            if (w_wr && (w_sel == SEL_STAT)) begin
                if (din[2]) r_overrun  <= 1'b0;
                if (din[3]) r_underrun <= 1'b0;
            end

            if (!w_active) begin
                r_cnt <= 3'd0;
            end else if (w_sample) begin
                r_rx_sh <= w_rx_byte[6:0];
                r_cnt   <= r_cnt + 3'd1;
            end

            if (w_load) begin
                if (r_tx_full) begin
                    r_tx_sh   <= r_txbuf;
                    r_tx_full <= 1'b0;
                end else begin
                    r_tx_sh    <= 8'hFF;
                    r_underrun <= 1'b1;
                end
            end else if (w_shift) begin
                r_tx_sh <= {r_tx_sh[6:0], 1'b1};
            end

            if (w_rd_rx)
                r_rx_full <= 1'b0;
            if (w_done) begin
                if (!r_rx_full || w_rd_rx) begin
                    r_rxdata  <= w_rx_byte;
                    r_rx_full <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            // A CPU write after a same-clk load leaves the new byte pending.
            if (w_wr && (w_sel == SEL_TX)) begin
                r_txbuf   <= din;
                r_tx_full <= 1'b1;
            end

            r_irq <= r_irq_en & (r_rx_full | r_overrun);
        end
    end

    assign dout    = r_dout;
    assign miso    = w_active ? r_tx_sh[7] : 1'b1;
    assign miso_oe = w_active;
    assign irq     = r_irq;
endmodule

// File: tb/tb_spi_slave_top.sv
// Bench for spi_slave_top: bit-banged SPI master, vector table, corner sequences
// and a randomized phase checked against a byte-level buffer model.
module tb_spi_slave_top;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] addr = 8'h00, din = 8'h00, dout;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic       sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
    logic       miso, miso_oe, irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mo[4];
    logic [7:0] m_mi[4];
    logic [7:0] m_coinc;

    // byte-level reference state
    logic [7:0] md_txbuf, md_rxdata;
    logic       md_txfull, md_rxfull, md_ovr, md_und;

    typedef struct {
        logic [7:0] con;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_mi;
        logic [7:0] exp_rx;
        logic [7:0] exp_stat;
    } vec_t;
    vec_t vecs[6];

    spi_slave_top dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
        .wr_en(wr_en), .rd_en(rd_en), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .miso_oe(miso_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h expected=%02h", name, got, exp);
        end else begin
            $display("ok   %s = %02h", name, got);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; din = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d = dout;
    endtask

    task automatic configure(input logic [7:0] con);
        sclk = con[1];
        wait_ticks(4);
        cpu_write(8'h00, con);
    endtask

    task automatic coinc_read();
        tick(); tick();
        addr = 8'h03; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        m_coinc = dout;
        wait_ticks(HALF - 3);
    endtask

    // Master: sends nbits from m_mo MSB first, captures miso into m_mi.
    task automatic xfer(input logic cpol, input logic cpha, input int nbits, input bit coinc);
        logic [7:0] sh = 8'h00;
        ss_n = 1'b0;
        wait_ticks(HALF);
        for (int b = 0; b < nbits; b++) begin
            logic [7:0] cur;
            cur = m_mo[b/8];
            if (!cpha) begin
                mosi = cur[7 - (b % 8)];
                wait_ticks(HALF);
                sh = {sh[6:0], miso};
                sclk = ~cpol;
                if (coinc && b == nbits - 1) coinc_read();
                else wait_ticks(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = cur[7 - (b % 8)];
                wait_ticks(HALF);
                sh = {sh[6:0], miso};
                sclk = cpol;
                if (coinc && b == nbits - 1) coinc_read();
                else wait_ticks(HALF);
            end
            if (b % 8 == 7) m_mi[b/8] = sh;
        end
        wait_ticks(HALF);
        ss_n = 1'b1;
        wait_ticks(HALF);
    endtask

    task automatic mdl_load(output logic [7:0] v);
        if (md_txfull) begin
            v = md_txbuf;
            md_txfull = 1'b0;
        end else begin
            v = 8'hFF;
            md_und = 1'b1;
        end
    endtask

    task automatic mdl_rx(input logic [7:0] v);
        if (!md_rxfull) begin
            md_rxdata = v;
            md_rxfull = 1'b1;
        end else begin
            md_ovr = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] d, v, con, t;
        logic [7:0] exp_mi[4];
        logic [1:0] mode;
        logic       ien;
        int         nb;

        vecs[0] = '{8'h01, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h09};
        vecs[1] = '{8'h05, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h01};
        vecs[2] = '{8'h03, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h09};
        vecs[3] = '{8'h07, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h01};
        vecs[4] = '{8'h01, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h09};
        vecs[5] = '{8'h07, 8'h80, 8'h01, 8'h80, 8'h01, 8'h01};

        wait_ticks(3);
        reset_n = 1'b1;
        tick();
        check("reset_dout", dout, 8'h00);
        check("reset_miso", {7'h0, miso}, 8'h01);
        check("reset_miso_oe", {7'h0, miso_oe}, 8'h00);
        check("reset_irq", {7'h0, irq}, 8'h00);
        cpu_read(8'h01, d); check("reset_stat", d, 8'h00);
        cpu_read(8'h02, d); check("reset_txbuf", d, 8'h00);

        // single-byte frames in all four modes
        foreach (vecs[i]) begin
            configure(vecs[i].con);
            cpu_write(8'h01, 8'h0C);
            cpu_write(8'h02, vecs[i].tx);
            m_mo[0] = vecs[i].mo;
            xfer(vecs[i].con[1], vecs[i].con[2], 8, 1'b0);
            check($sformatf("vec%0d_miso", i), m_mi[0], vecs[i].exp_mi);
            cpu_read(8'h01, d); check($sformatf("vec%0d_stat", i), d, vecs[i].exp_stat);
            cpu_read(8'h03, d); check($sformatf("vec%0d_rx", i), d, vecs[i].exp_rx);
            cpu_read(8'h01, d); check($sformatf("vec%0d_stat_rd", i), d, vecs[i].exp_stat & 8'hFE);
            cpu_write(8'h01, 8'h0C);
        end

        // two bytes, one TX byte, no RX read
        configure(8'h01);
        cpu_write(8'h02, 8'h11);
        m_mo[0] = 8'hAB; m_mo[1] = 8'hCD;
        xfer(1'b0, 1'b0, 16, 1'b0);
        check("two_miso0", m_mi[0], 8'h11);
        check("two_miso1", m_mi[1], 8'hFF);
        cpu_read(8'h01, d); check("two_stat", d, 8'h0D);
        cpu_read(8'h03, d); check("two_rx", d, 8'hAB);
        cpu_write(8'h01, 8'h0C);
        cpu_read(8'h01, d); check("two_stat_clr", d, 8'h00);

        // abort after four bits, then a clean frame
        cpu_write(8'h02, 8'h5A);
        m_mo[0] = 8'hF0;
        xfer(1'b0, 1'b0, 4, 1'b0);
        cpu_read(8'h01, d); check("abort_stat", d, 8'h00);
        cpu_write(8'h02, 8'h96);
        m_mo[0] = 8'hC3;
        xfer(1'b0, 1'b0, 8, 1'b0);
        check("abort_next_miso", m_mi[0], 8'h96);
        cpu_read(8'h03, d); check("abort_next_rx", d, 8'hC3);
        cpu_write(8'h01, 8'h0C);

        // RX read in the same clk as byte complete
        configure(8'h09);
        cpu_write(8'h02, 8'h77);
        m_mo[0] = 8'h12;
        xfer(1'b0, 1'b0, 8, 1'b0);
        m_mo[0] = 8'h34;
        xfer(1'b0, 1'b0, 8, 1'b1);
        check("coinc_dout", m_coinc, 8'h12);
        cpu_read(8'h01, d); check("coinc_rxfull_ovr", d & 8'h05, 8'h01);
        check("coinc_irq", {7'h0, irq}, 8'h01);
        cpu_read(8'h03, d); check("coinc_rx", d, 8'h34);
        wait_ticks(2);
        check("coinc_irq_clr", {7'h0, irq}, 8'h00);
        cpu_write(8'h01, 8'h0C);

        // reset pulse mid-byte
        cpu_write(8'h02, 8'h44);
        m_mo[0] = 8'h99;
        xfer(1'b0, 1'b0, 8, 1'b0);
        cpu_read(8'h00, d);
        check("rst_pre_irq", {7'h0, irq}, 8'h01);
        ss_n = 1'b0;
        wait_ticks(HALF);
        for (int k = 0; k < 3; k++) begin
            mosi = 1'b1; wait_ticks(HALF);
            sclk = 1'b1; wait_ticks(HALF);
            sclk = 1'b0;
        end
        check("rst_pre_oe", {7'h0, miso_oe}, 8'h01);
        reset_n = 1'b0;
        #2;
        check("rst_dout", dout, 8'h00);
        check("rst_miso", {7'h0, miso}, 8'h01);
        check("rst_oe", {7'h0, miso_oe}, 8'h00);
        check("rst_irq", {7'h0, irq}, 8'h00);
        tick();
        reset_n = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wait_ticks(4);
        cpu_read(8'h00, d); check("rst_con", d, 8'h00);
        cpu_read(8'h01, d); check("rst_stat", d, 8'h00);
        configure(8'h01);
        cpu_write(8'h02, 8'h5A);
        m_mo[0] = 8'h81;
        xfer(1'b0, 1'b0, 8, 1'b0);
        check("rst_next_miso", m_mi[0], 8'h5A);
        cpu_read(8'h03, d); check("rst_next_rx", d, 8'h81);

        // randomized frames against the byte-level model, from a fresh reset
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        md_txbuf = 8'h00; md_rxdata = 8'h00;
        md_txfull = 1'b0; md_rxfull = 1'b0; md_ovr = 1'b0; md_und = 1'b0;
        for (int it = 0; it < 30; it++) begin
            mode = 2'($urandom_range(0, 3));
            ien  = 1'($urandom_range(0, 1));
            con  = {4'h0, ien, mode[0], mode[1], 1'b1};
            configure(con);
            if ($urandom_range(0, 2) != 0) begin
                v = 8'($urandom);
                cpu_write(8'h02, v);
                md_txbuf = v; md_txfull = 1'b1;
            end
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) m_mo[i] = 8'($urandom);
            if (!mode[0]) mdl_load(exp_mi[0]);
            for (int i = 0; i < nb; i++) begin
                if (mode[0]) mdl_load(exp_mi[i]);
                mdl_rx(m_mo[i]);
                if (!mode[0]) begin
                    mdl_load(t);
                    if (i + 1 < nb) exp_mi[i+1] = t;
                end
            end
            xfer(mode[1], mode[0], nb * 8, 1'b0);
            for (int i = 0; i < nb; i++)
                check($sformatf("rnd%0d_miso%0d", it, i), m_mi[i], exp_mi[i]);
            cpu_read(8'h01, d);
            check($sformatf("rnd%0d_stat", it), d, {4'h0, md_und, md_ovr, md_txfull, md_rxfull});
            tick();
            check($sformatf("rnd%0d_irq", it), {7'h0, irq}, {7'h0, ien & (md_rxfull | md_ovr)});
            if ($urandom_range(0, 1) == 1) begin
                cpu_read(8'h03, d);
                check($sformatf("rnd%0d_rx", it), d, md_rxdata);
                md_rxfull = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                cpu_read(8'h02, d);
                check($sformatf("rnd%0d_txbuf", it), d, md_txbuf);
            end
            if ($urandom_range(0, 1) == 1) begin
                v = 8'($urandom);
                cpu_write(8'h01, v);
                if (v[2]) md_ovr = 1'b0;
                if (v[3]) md_und = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
